// File: rtl/sd_spi_responder.sv
// SPI-mode SD card model (card side) serving CMD0/8/55/ACMD41/16/17/24 from a byte-wide memory.
// Define SD_RESP_CRC16_EN to send a real CRC16-CCITT after read data instead of 0xFF 0xFF.
module sd_spi_responder #(
   parameter int unsigned SECT_W     = 4,
   parameter int unsigned INIT_COUNT = 2,
   parameter int unsigned NAC_BYTES  = 2,
   parameter int unsigned BUSY_BYTES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              sclk,
   input  logic              mosi,
   output logic              miso,
   output logic [SECT_W+8:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              initialized,
   output logic [3:0]        status
);

   typedef enum logic [3:0] {
      StHunt, StCmd, StExec, StRdGap, StRdData, StRdCrc, StWrToken, StWrData, StWrCrc, StWrBusy
   } state_e;

   logic cs_meta_q, cs_sync_q, sclk_meta_q, sclk_sync_q, sclk_prev_q, mosi_meta_q, mosi_sync_q;
   logic sclk_rise, sclk_fall;

   state_e              state_q, state_d, post_q, post_d;
   logic [2:0]          bit_q, bit_d, rcnt_q, rcnt_d;
   logic [6:0]          rx_q, rx_d;
   logic [7:0]          tx_q, tx_d, nxt_q, nxt_d, cnt_q, cnt_d, acnt_q, acnt_d;
   logic [7:0]          wdata_q, wdata_d;
   logic [5:0]          cmd_q, cmd_d;
   logic [31:0]         arg_q, arg_d;
   logic [39:0]         resp_q, resp_d;
   logic [8:0]          idx_q, idx_d;
   logic [SECT_W-1:0]   sector_q, sector_d;
   logic [SECT_W+8:0]   addr_q, addr_d;
   logic                we_q, we_d, idle_q, idle_d, app_q, app_d, init_q, init_d;
   logic                byte_done;
   logic [7:0]          rx_byte, r1;

`ifdef SD_RESP_CRC16_EN
   logic [15:0] crc_q, crc_d;

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      end
      return r;
   endfunction
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_meta_q   <= 1'b1;
         cs_sync_q   <= 1'b1;
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_prev_q <= 1'b0;
         mosi_meta_q <= 1'b1;
         mosi_sync_q <= 1'b1;
      end else begin
         cs_meta_q   <= cs;
         cs_sync_q   <= cs_meta_q;
         sclk_meta_q <= sclk;
         sclk_sync_q <= sclk_meta_q;
         sclk_prev_q <= sclk_sync_q;
         mosi_meta_q <= mosi;
         mosi_sync_q <= mosi_meta_q;
      end
   end

   assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
   assign sclk_fall = ~sclk_sync_q & sclk_prev_q;

   always_comb begin
      state_d   = state_q;
      post_d    = post_q;
      bit_d     = bit_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      nxt_d     = nxt_q;
      cmd_d     = cmd_q;
      arg_d     = arg_q;
      cnt_d     = cnt_q;
      resp_d    = resp_q;
      rcnt_d    = rcnt_q;
      idx_d     = idx_q;
      sector_d  = sector_q;
      addr_d    = addr_q;
      we_d      = 1'b0;
      wdata_d   = wdata_q;
      idle_d    = idle_q;
      app_d     = app_q;
      init_d    = init_q;
      acnt_d    = acnt_q;
`ifdef SD_RESP_CRC16_EN
      crc_d     = crc_q;
`endif
      byte_done = 1'b0;
      r1        = 8'h04 | {7'd0, idle_q};
      rx_byte   = {rx_q, mosi_sync_q};

      // cs high wins over any coincident sclk edge
      if (cs_sync_q) begin
         state_d = StHunt;
         bit_d   = 3'd0;
         tx_d    = 8'hFF;
         nxt_d   = 8'hFF;
      end else begin
         if (sclk_fall) begin
            tx_d = (bit_q == 3'd0) ? nxt_q : {tx_q[6:0], 1'b1};
         end
         if (sclk_rise) begin
            rx_d      = rx_byte[6:0];
            bit_d     = bit_q + 3'd1;
            byte_done = (bit_q == 3'd7);
         end
         // Each completed byte decides the byte shifted out in the next slot.
         if (byte_done) begin
            nxt_d = 8'hFF;
            case (state_q)
               StHunt: begin
                  if (rx_byte[7:6] == 2'b01) begin
                     cmd_d   = rx_byte[5:0];
                     cnt_d   = 8'd0;
                     state_d = StCmd;
                  end
               end
               StCmd: begin
                  if (cnt_q != 8'd4) begin
                     arg_d = {arg_q[23:0], rx_byte};
                     cnt_d = cnt_q + 8'd1;
                  end else begin
                     state_d = StExec;
                     post_d  = StHunt;
                     rcnt_d  = 3'd1;
                     app_d   = 1'b0;
                     case (cmd_q)
                        6'd0: begin
                           idle_d = 1'b1;
                           init_d = 1'b0;
                           acnt_d = 8'd0;
                           r1     = 8'h01;
                        end
                        6'd8:  r1 = 8'h01;
                        6'd55: begin
                           app_d = 1'b1;
                           r1    = {7'd0, idle_q};
                        end
                        6'd41: begin
                           if (app_q) begin
                              if (acnt_q < 8'(INIT_COUNT)) begin
                                 acnt_d = acnt_q + 8'd1;
                                 r1     = 8'h01;
                              end else begin
                                 idle_d = 1'b0;
                                 init_d = 1'b1;
                                 r1     = 8'h00;
                              end
                           end
                        end
                        6'd16: r1 = 8'h00;
                        6'd17, 6'd24: begin
                           if (idle_q) begin
                              r1 = 8'h05;
                           end else if ((arg_q >> (9 + SECT_W)) != 32'd0) begin
                              r1 = 8'h40;
                           end else begin
                              r1       = 8'h00;
                              sector_d = arg_q[SECT_W+8:9];
                              idx_d    = 9'd0;
                              addr_d   = {arg_q[SECT_W+8:9], 9'd0};
                              cnt_d    = 8'd0;
                              post_d   = (cmd_q == 6'd17) ? StRdGap : StWrToken;
`ifdef SD_RESP_CRC16_EN
                              crc_d    = 16'h0000;
`endif
                           end
                        end
                        default: ;
                     endcase
                     resp_d = {r1, 32'hFFFF_FFFF};
                     if (cmd_q == 6'd8) begin
                        resp_d = {8'h01, 16'h0000, 4'h0, arg_q[11:0]};
                        rcnt_d = 3'd5;
                     end
                  end
               end
               StExec: begin
                  nxt_d  = resp_q[39:32];
                  resp_d = {resp_q[31:0], 8'hFF};
                  rcnt_d = rcnt_q - 3'd1;
                  if (rcnt_q == 3'd1) state_d = post_q;
               end
               StRdGap: begin
                  if (cnt_q < 8'(NAC_BYTES)) begin
                     cnt_d = cnt_q + 8'd1;
                  end else begin
                     nxt_d   = 8'hFE;
                     state_d = StRdData;
                  end
               end
               StRdData: begin
                  nxt_d  = mem_rdata;
                  idx_d  = idx_q + 9'd1;
                  addr_d = {sector_q, idx_q + 9'd1};
`ifdef SD_RESP_CRC16_EN
                  crc_d  = crc16_byte(crc_q, mem_rdata);
`endif
                  if (&idx_q) begin
                     state_d = StRdCrc;
                     cnt_d   = 8'd0;
                  end
               end
               StRdCrc: begin
`ifdef SD_RESP_CRC16_EN
                  nxt_d = (cnt_q == 8'd0) ? crc_q[15:8] : crc_q[7:0];
`endif
                  cnt_d = cnt_q + 8'd1;
                  if (cnt_q == 8'd1) state_d = StHunt;
               end
               StWrToken: begin
                  if (rx_byte == 8'hFE) begin
                     state_d = StWrData;
                     idx_d   = 9'd0;
                  end
               end
               StWrData: begin
                  we_d    = 1'b1;
                  wdata_d = rx_byte;
                  addr_d  = {sector_q, idx_q};
                  idx_d   = idx_q + 9'd1;
                  if (&idx_q) begin
                     state_d = StWrCrc;
                     cnt_d   = 8'd0;
                  end
               end
               StWrCrc: begin
                  if (cnt_q == 8'd1) begin
                     nxt_d   = 8'h05;
                     state_d = StWrBusy;
                     cnt_d   = 8'd0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
               StWrBusy: begin
                  if (cnt_q < 8'(BUSY_BYTES)) begin
                     nxt_d = 8'h00;
                     cnt_d = cnt_q + 8'd1;
                  end else begin
                     state_d = StHunt;
                  end
               end
               default: state_d = StHunt;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StHunt;
         post_q   <= StHunt;
         bit_q    <= '0;
         rx_q     <= '0;
         tx_q     <= 8'hFF;
         nxt_q    <= 8'hFF;
         cmd_q    <= '0;
         arg_q    <= '0;
         cnt_q    <= '0;
         resp_q   <= '1;
         rcnt_q   <= '0;
         idx_q    <= '0;
         sector_q <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         idle_q   <= 1'b1;
         app_q    <= 1'b0;
         init_q   <= 1'b0;
         acnt_q   <= '0;
`ifdef SD_RESP_CRC16_EN
         crc_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         post_q   <= post_d;
         bit_q    <= bit_d;
         rx_q     <= rx_d;
         tx_q     <= tx_d;
         nxt_q    <= nxt_d;
         cmd_q    <= cmd_d;
         arg_q    <= arg_d;
         cnt_q    <= cnt_d;
         resp_q   <= resp_d;
         rcnt_q   <= rcnt_d;
         idx_q    <= idx_d;
         sector_q <= sector_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         idle_q   <= idle_d;
         app_q    <= app_d;
         init_q   <= init_d;
         acnt_q   <= acnt_d;
`ifdef SD_RESP_CRC16_EN
         crc_q    <= crc_d;
`endif
      end
   end

   assign miso        = tx_q[7];
   assign mem_addr    = addr_q;
   assign mem_we      = we_q;
   assign mem_wdata   = wdata_q;
   assign initialized = init_q;
   assign status      = state_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: SPI host tasks, byte memory model and a queue of expected miso bytes.
module tb_sd_spi_responder;

   localparam int unsigned SECT_W    = 4;
   localparam int          MEM_BYTES = 1 << (SECT_W + 9);
   localparam int          HALF      = 30;

   logic              clk = 1'b0;
   logic              reset, cs, sclk, mosi, miso, mem_we, initialized;
   logic [SECT_W+8:0] mem_addr;
   logic [7:0]        mem_wdata, mem_rdata;
   logic [3:0]        status;
   logic [7:0]        mem [MEM_BYTES];

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  exp_q [$];

   sd_spi_responder #(
      .SECT_W    (SECT_W),
      .INIT_COUNT(2),
      .NAC_BYTES (2),
      .BUSY_BYTES(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cs         (cs),
      .sclk       (sclk),
      .mosi       (mosi),
      .miso       (miso),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .initialized(initialized),
      .status     (status)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr];
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic xfer(input logic [7:0] tx_byte, output logic [7:0] rx_byte);
      for (int i = 7; i >= 0; i--) begin
         mosi = tx_byte[i];
         #(HALF);
         rx_byte[i] = miso;
         sclk = 1'b1;
         #(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic xfer_chk(input string tag, input logic [7:0] tx_byte);
      logic [7:0] rx, e;
      xfer(tx_byte, rx);
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: got 0x%0h, expected nothing queued", tag, rx);
      end else begin
         e = exp_q.pop_front();
         check_eq(tag, {24'd0, rx}, {24'd0, e});
      end
   endtask

   task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
      logic [7:0] rx;
      xfer({2'b01, idx}, rx);
      for (int i = 3; i >= 0; i--) xfer(arg[8*i +: 8], rx);
      xfer(crc, rx);
   endtask

   task automatic cs_low();
      cs = 1'b0;
      #30;
   endtask

   task automatic cs_high();
      #30;
      cs = 1'b1;
      #60;
   endtask

   // Two-byte exchange: NCR filler then R1.
   task automatic cmd_r1(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [7:0] crc, input logic [7:0] r1);
      exp_q.push_back(8'hFF);
      exp_q.push_back(r1);
      cs_low();
      send_cmd(idx, arg, crc);
      xfer_chk(tag, 8'hFF);
      xfer_chk(tag, 8'hFF);
      cs_high();
   endtask

`ifdef SD_RESP_CRC16_EN
   function automatic logic [15:0] crc16_ref();
      logic [15:0] c;
      logic [7:0]  d;
      logic        fb;
      c = 16'h0000;
      for (int n = 0; n < 512; n++) begin
         d = 8'(n);
         for (int b = 7; b >= 0; b--) begin
            fb = c[15] ^ d[b];
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction
`endif

   initial begin
      logic [7:0]  rx;
      logic [15:0] crc;
      reset = 1'b1;
      cs    = 1'b1;
      sclk  = 1'b0;
      mosi  = 1'b1;
      #40;
      reset = 1'b0;
      #20;

      check_eq("rst_miso", {31'd0, miso}, 32'd1);
      check_eq("rst_status", {28'd0, status}, 32'd0);
      check_eq("rst_init", {31'd0, initialized}, 32'd0);
      check_eq("rst_we", {31'd0, mem_we}, 32'd0);
      check_eq("rst_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_wdata", {24'd0, mem_wdata}, 32'd0);

      cmd_r1("cmd0", 6'd0, 32'h0, 8'h95, 8'h01);
      check_eq("cmd0_init", {31'd0, initialized}, 32'd0);

      foreach (exp_q[i]) exp_q.delete(i);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'hAA);
      cs_low();
      send_cmd(6'd8, 32'h0000_01AA, 8'h87);
      for (int i = 0; i < 6; i++) xfer_chk("cmd8_r7", 8'hFF);
      cs_high();

      for (int k = 0; k < 3; k++) begin
         cmd_r1("cmd55", 6'd55, 32'h0, 8'h65, 8'h01);
         cmd_r1("acmd41", 6'd41, 32'h4000_0000, 8'h77, (k < 2) ? 8'h01 : 8'h00);
         check_eq("acmd41_init", {31'd0, initialized}, (k == 2) ? 32'd1 : 32'd0);
      end

      cmd_r1("cmd16", 6'd16, 32'h200, 8'hFF, 8'h00);
      cmd_r1("cmd1_unknown", 6'd1, 32'h0, 8'hFF, 8'h04);
      cmd_r1("cmd41_no_app", 6'd41, 32'h0, 8'hFF, 8'h04);

      // Sector write to byte address 0x200 with pattern i[7:0]
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      cs_low();
      send_cmd(6'd24, 32'h0000_0200, 8'hFF);
      xfer_chk("cmd24_r1", 8'hFF);
      xfer_chk("cmd24_r1", 8'hFF);
      xfer(8'hFF, rx);
      xfer(8'hFE, rx);
      for (int i = 0; i < 512; i++) xfer(8'(i), rx);
      xfer(8'hFF, rx);
      xfer(8'hFF, rx);
      exp_q.push_back(8'h05);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      for (int i = 0; i < 6; i++) xfer_chk("cmd24_resp", 8'hFF);
      cs_high();
      for (int i = 0; i < 512; i++) check_eq("wr_mem", {24'd0, mem[512 + i]}, 32'(i[7:0]));
      check_eq("wr_mem_below", {24'd0, mem[511]}, 32'd0);
      check_eq("wr_mem_above", {24'd0, mem[1024]}, 32'd0);

      // Sector read back
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFE);
      for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
`ifdef SD_RESP_CRC16_EN
      crc = crc16_ref();
`else
      crc = 16'hFFFF;
`endif
      exp_q.push_back(crc[15:8]);
      exp_q.push_back(crc[7:0]);
      cs_low();
      send_cmd(6'd17, 32'h0000_0200, 8'hFF);
      for (int i = 0; i < 5; i++) xfer_chk("cmd17_hdr", 8'hFF);
      for (int i = 0; i < 512; i++) xfer_chk("rd_data", 8'hFF);
      xfer_chk("rd_crc", 8'hFF);
      xfer_chk("rd_crc", 8'hFF);
      cs_high();

      cmd_r1("cmd17_range", 6'd17, 32'h0000_2000, 8'hFF, 8'h40);

      // Abort a read after 100 bytes on the bus
      cs_low();
      send_cmd(6'd17, 32'h0000_0200, 8'hFF);
      for (int i = 0; i < 94; i++) xfer(8'hFF, rx);
      cs_high();
      check_eq("abort_miso", {31'd0, miso}, 32'd1);
      check_eq("abort_status", {28'd0, status}, 32'd0);
      check_eq("abort_init", {31'd0, initialized}, 32'd1);
      cmd_r1("cmd0_after_abort", 6'd0, 32'h0, 8'h95, 8'h01);
      check_eq("cmd0_deinit", {31'd0, initialized}, 32'd0);
      check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- Synthesizable SPI-mode SD card model: the card end of the link that our SD host controller drives.
- Decodes 6-byte command frames and answers CMD0/8/55/ACMD41/16/17/24 with R1/R7 responses.
- Serves 512-byte sector reads and accepts sector writes through a byte-wide backing-memory port.
- Used in simulation benches and as an on-board loopback target, so host-side tests run without a physical card.

Parameters:
- SECT_W, 4: sector-index width; memory holds 2^SECT_W sectors.
- INIT_COUNT, 2: number of ACMD41 calls answered 0x01 before the model returns 0x00.
- NAC_BYTES, 2: 0xFF bytes sent between the R1 of CMD17 and the 0xFE start token.
- BUSY_BYTES, 4: 0x00 busy bytes sent after a write data-response.

Ports:
- clk  in  1  system clock; must be at least 4x sclk.
- reset  in  1  asynchronous, active-high.
- cs  in  1  SPI chip select, active low.
- sclk  in  1  SPI clock, mode 0.
- mosi  in  1  host-to-card data.
- miso  out  1  card-to-host data.
- mem_addr  out  SECT_W+9  byte address = {sector, byte_idx}.
- mem_we  out  1  one-clk write strobe.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; valid 1 clk after mem_addr changes.
- initialized  out  1  1 once ACMD41 has returned 0x00.
- status  out  4  current FSM state encoding.

Behaviour:
- Input sync: cs, sclk and mosi pass through 2-flop synchronizers. Rising and falling edges of sclk are detected in the clk domain.
- Mode 0 timing: mosi is sampled on sclk rise; miso changes on sclk fall. Bit 7 of each tx byte is on miso before the first rise of that byte.
- Idle output: while cs is high, or when the model has nothing to send, miso = 1.
- Reset values: miso=1, mem_we=0, mem_addr=0, mem_wdata=0, initialized=0, status=HUNT, idle_flag=1, app_flag=0, ACMD41 counter=0.
- States:
  - HUNT: shifts bytes in. A byte matching 01xxxxxx starts a frame; 5 more bytes are collected (arg[31:0], crc; crc ignored) -> CMD_EXEC.
  - CMD_EXEC: sends one 0xFF (NCR), then the response. Afterwards -> HUNT, or RD_GAP / WR_TOKEN for data commands.
- Command responses:
  - CMD0: idle_flag=1, initialized=0, ACMD41 counter cleared; R1=0x01.
  - CMD8: R7 = 0x01, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0].
  - CMD55: app_flag=1; R1={7'b0, idle_flag}.
  - ACMD41 (CMD41 with app_flag set): counter increments. While counter < INIT_COUNT, R1=0x01. Then idle_flag=0, initialized=1, R1=0x00.
  - app_flag clears after any command other than CMD55.
  - CMD16: R1=0x00.
  - Unknown command, or CMD41 without app_flag: R1 = 0x04 | idle_flag.
  - CMD17/CMD24 while idle_flag=1: R1=0x05; no data phase.
- Addressing: arg is a byte address. Sector = arg[31:9]. If arg[31:9+SECT_W] != 0, R1=0x40 and there is no data phase.
- CMD17 read:
  - Sequence: R1=0x00, NAC_BYTES of 0xFF, token 0xFE, 512 data bytes from mem_rdata, 2 CRC bytes, then HUNT.
  - mem_addr for byte n+1 is issued while byte n is shifting (prefetch).
  - byte_idx counts 0..511 and wraps to 0 at sector end without changing the sector.
- CMD24 write:
  - Sends R1=0x00, then WR_TOKEN. Bytes other than 0xFE are ignored there (host sends 0xFF fill).
  - On 0xFE: receives 512 bytes. Each completed byte pulses mem_we for 1 clk with mem_addr={sector, idx}.
  - Then 2 CRC bytes (ignored), data response 0x05, BUSY_BYTES of 0x00, then 0xFF and -> HUNT.
- cs deassert mid-operation: frame, data or busy phase aborts at once; -> HUNT; miso=1. Bytes already written stay written. idle_flag and initialized are kept.
- Simultaneous events: a cs rise in the same clk as an sclk edge is handled as an abort; that edge is ignored.
- reset asserted mid-operation: all state returns to reset values asynchronously.

Optional Feature:
- Macro: SD_RESP_CRC16_EN.
- Defined: CRC16-CCITT (poly 0x1021, init 0x0000) is accumulated over the 512 read bytes and sent MSB-first as the 2 CRC bytes.
- Not defined: the CRC bytes are 0xFF, 0xFF and no CRC logic is present.
- Write-path CRC is ignored in both builds.

Test Plan:
- Reset, then CMD0 (40 00 00 00 00 95) -> miso bytes FF, 01; initialized=0.
- CMD8 with arg 0x000001AA -> FF, 01, 00, 00, 01, AA.
- CMD55 + ACMD41 twice with INIT_COUNT=2 -> R1 01, 01, then 00 on the third pair; initialized=1.
- CMD24 to addr 0x200, token FE, data bytes = i[7:0] -> response 05, four 00, then FF; mem written at 0x200..0x3FF.
- CMD17 to addr 0x200 -> 00, FF, FF, FE, bytes 00..FF twice; CRC = FF FF, or the true CRC16 with SD_RESP_CRC16_EN. CMD17 to sector 16 with SECT_W=4 -> 0x40.
- Raise cs after 100 bytes of a CMD17 -> miso=1 and status=HUNT; the next CMD0 returns 01.
